// File: rtl/aes_pkg.sv
// Shared types, mode constants, S-box table and GF helpers for the AES key schedule.
package aes_pkg;

  typedef enum logic [1:0] {AES128, AES192, AES256, RSVD} key_len_t;
  typedef enum logic {IDLE, GEN} sched_state_t;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 6 + NK_128;
  localparam int NR_192 = 6 + NK_192;
  localparam int NR_256 = 6 + NK_256;

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input key_len_t k);
    case (k)
      AES128:  return 4'(NK_128);
      AES192:  return 4'(NK_192);
      AES256:  return 4'(NK_256);
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_t k);
    case (k)
      AES128:  return 4'(NR_128);
      AES192:  return 4'(NR_192);
      AES256:  return 4'(NR_256);
      default: return 4'd0;
    endcase
  endfunction

  // Total schedule length in words: 4*(Nr+1).
  function automatic logic [5:0] nw_of(input key_len_t k);
    case (k)
      AES128:  return 6'(4 * (NR_128 + 1));
      AES192:  return 6'(4 * (NR_192 + 1));
      AES256:  return 6'(4 * (NR_256 + 1));
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup (combinational ROM).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX_TABLE[(255 - int'(in_byte)) * 8 +: 8];

endmodule

// File: rtl/key_word_xform.sv
// Key-schedule word transform: optional RotWord, SubWord, then rcon into the top byte.
module key_word_xform (
  input  logic [31:0] word_in,
  input  logic        rot_en,
  input  logic [7:0]  rcon_byte,
  output logic [31:0] word_out
);

  logic [31:0] rotWord;
  logic [31:0] subWord;

  assign rotWord = rot_en ? {word_in[23:0], word_in[31:24]} : word_in;

  for (genvar b = 0; b < 4; b++) begin : gSbox
    aes_sbox uSbox (
      .in_byte  (rotWord[8*b +: 8]),
      .out_byte (subWord[8*b +: 8])
    );
  end

  assign word_out = subWord ^ {rcon_byte, 24'h0};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion, one word per clock, with a registered round-key read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_NK      = 8,
  parameter int SCHED_WORDS = 4 * (MAX_NK + 7)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  sched_state_t state, stateNext;
  key_len_t     modeReg, modeIn;
  logic [5:0]   wordIdx;
  logic [2:0]   phase;
  logic [7:0]   rcon;
  logic [3:0]   nkReg;
  logic         legal, accept, reject, lastWord, applyXform, rotEn;
  logic [31:0]  prevWord, backWord, xformWord, newWord;
  logic [5:0]   readBase;
  logic [31:0]  sched [SCHED_WORDS];

  // Start qualification, next-state selection and the busy flag.
  always_comb begin
    stateNext = state;
    busy      = (state == GEN);
    modeIn    = key_len_t'(key_len);
    legal     = (modeIn != RSVD) && (int'(nk_of(modeIn)) <= MAX_NK);
    accept    = 1'b0;
    reject    = 1'b0;
    lastWord  = 1'b0;
    case (state)
      IDLE: begin
        accept = start && legal;
        reject = start && !legal;
        if (accept) stateNext = GEN;
      end
      GEN: begin
        lastWord = (wordIdx == nw_of(modeReg) - 6'd1);
        if (lastWord) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // The next word depends on w[i-1] and w[i-Nk]; the transform fires at phase 0 and, for 256-bit keys, phase 4.
  assign nkReg      = nk_of(modeReg);
  assign prevWord   = sched[wordIdx - 6'd1];
  assign backWord   = sched[wordIdx - {2'b00, nkReg}];
  assign rotEn      = (phase == 3'd0);
  assign applyXform = rotEn || ((modeReg == AES256) && (phase == 3'd4));
  assign newWord    = backWord ^ (applyXform ? xformWord : prevWord);

  key_word_xform uXform (
    .word_in   (prevWord),
    .rot_en    (rotEn),
    .rcon_byte (rotEn ? rcon : 8'h00),
    .word_out  (xformWord)
  );

  // Word counter, mod-Nk phase, rcon and the status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      modeReg <= AES128;
      wordIdx <= 6'd0;
      phase   <= 3'd0;
      rcon    <= 8'h01;
      valid   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      if (accept) begin
        modeReg <= modeIn;
        wordIdx <= {2'b00, nk_of(modeIn)};
        phase   <= 3'd0;
        rcon    <= 8'h01;
        valid   <= 1'b0;
      end else if (state == GEN) begin
        wordIdx <= wordIdx + 6'd1;
        phase   <= ({1'b0, phase} == nkReg - 4'd1) ? 3'd0 : phase + 3'd1;
        if (rotEn) rcon <= xtime(rcon);
        if (lastWord) begin
          valid <= 1'b1;
          done  <= 1'b1;
        end
      end
    end
  end

  // Schedule store: key words on accept, one expanded word per GEN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(nk_of(modeIn))) sched[k] <= key_in[255 - 32*k -: 32];
      end
    end else if (state == GEN) begin
      sched[wordIdx] <= newWord;
    end
  end

  assign readBase = {rk_idx, 2'b00};

  // Registered round-key read; zero unless a complete schedule holds that round.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out <= '0;
    end else if (valid && (rk_idx <= nr_of(modeReg))) begin
      rk_out <= {sched[readBase], sched[readBase + 6'd1],
                 sched[readBase + 6'd2], sched[readBase + 6'd3]};
    end else begin
      rk_out <= '0;
    end
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential, parametrised AES key-expansion engine that replaces per-round combinational round-key logic.
- Accepts an AES-128, -192 or -256 cipher key and expands it one 32-bit word per clock into an internal schedule store (up to 60 words).
- Serves round keys 0..Nr to the cipher/decipher datapath through a registered read port.
- Sits between the SD-card command/key-load logic and the AES round engine.

Parameters:
- MAX_NK, 8, largest supported key length in words: 4 = AES-128 only, 6 = up to AES-192, 8 = all three modes.
- SCHED_WORDS, 4*(MAX_NK+7), depth of the schedule store (60 when MAX_NK=8).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request an expansion; accepted only while busy=0
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
- key_in  in  256  cipher key, w0 = key_in[255:224]; unused low words are ignored
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the schedule is complete
- valid  out  1  schedule complete and readable
- err  out  1  one-cycle pulse when a start is rejected
- rk_idx  in  4  requested round number
- rk_out  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, rcon = 0x01, the word counter is 0, and the schedule contents are don't-care.
- Mode constants:
  - Nk = 4, 6, 8.
  - Nr = 6 + Nk.
  - Nw = 4*(Nr+1) = 44, 52, 60 words.
- Start rejection:
  - key_len=3 pulses err and does not start.
  - A key_len whose Nk exceeds MAX_NK pulses err and does not start.
- FSM states: IDLE, GEN.
  - Accepted start is start & !busy with a legal key_len.
  - On that edge: write words 0..Nk-1 from key_in, latch the mode, set i=Nk, set the mod-Nk phase counter to 0, set rcon=0x01, set busy=1, clear valid, and go to GEN.
- GEN: each cycle writes w[i] = w[i-Nk] ^ temp, where temp starts as w[i-1] and is modified as follows.
  - Phase 0 (i mod Nk == 0): temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}; then rcon = xtime(rcon) in GF(2^8) with reduction polynomial 0x11B.
  - Nk=8 and phase 4: temp = SubWord(temp).
  - The phase counter increments and wraps at Nk-1. No divider is used.
- Completion: on the edge that writes w[Nw-1], return to IDLE, clear busy, set valid=1, and assert done for exactly one cycle.
  - done is high 40 / 46 / 52 cycles after the accept edge for AES-128 / -192 / -256.
- start while busy: ignored, with no err pulse.
- New start while valid=1: valid drops on the accept edge. The old schedule is no longer readable.
- rst mid-expansion: return to IDLE next edge with busy=0, valid=0, done=0. No partial result is ever flagged valid.
- Read port: rk_out is registered, one-cycle latency from rk_idx.
  - rk_out = 0 when valid=0 or rk_idx > Nr.
  - Reads during GEN return 0.
- Widths: all arithmetic is XOR or GF byte ops; there is no carry arithmetic. The i counter is 6 bits; the phase counter is 3 bits.

Decomposition:
- Shared package aes_pkg holds:
  - key_len_t enum (AES128, AES192, AES256, RSVD);
  - constants NK_128/192/256 and NR_*;
  - function xtime;
  - function nw_of(key_len_t).
- Sub-module key_word_xform, which is combinational:
  - inputs: word_in[31:0], rot_en, rcon_byte[7:0];
  - output: SubWord of the optionally rotated word, XOR rcon in the top byte.
  - It instantiates four shared aes_sbox lookups.
- The FSM, counters and schedule store stay in aes_key_schedule.

Test Plan:
- AES-128 vector: key_len=0, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start -> done 40 cycles after accept; rk_idx=10 gives rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=0 returns the key.
- AES-192 vector: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> done at 46 cycles; rk_idx=12 low word (w[51]) = 01002202; rk_idx=13 gives 0.
- AES-256 vector: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> done at 52 cycles; rk_idx=14 low word (w[59]) = 706c631e.
- Illegal and overlapping starts: key_len=3 start -> err pulses once, busy stays 0; start asserted on cycle 5 of a GEN -> ignored, completion timing unchanged.
- Reset mid-run: rst at cycle 20 of an AES-256 expansion -> next cycle busy=0, valid=0, rk_out=0; a subsequent AES-128 run produces the correct vector result.
- Re-key: after a valid AES-256 schedule, start AES-128 -> valid drops on the accept edge; after done, rk_idx=11 returns 0 and rk_idx=10 returns the new key.
